ram_fifo_ctrl: RTL
==================

// Module: ram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller that owns the single-port 64x64 ram and is its only master.
//  Upstream producers push words; the block writes them to the ram, reads them back in order, and presents them downstream.
//  After reset it sweeps the ram to zero before any traffic, since ram contents are undefined at power-up.
//  One ram access (write or read) per clock cycle.
// PARAMETERS
//  DW     64   data width; matches ram data_in/data_out
//  AW     6    address width; matches ram addr
//  DEPTH  64   FIFO depth; must equal 2**AW
// PORTS
//  clk         in   1      clock; all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  push_valid  in   1      producer has a word on push_data
//  push_data   in   DW     word to store
//  push_ready  out  1      push accepted this cycle when push_valid && push_ready
//  pop_valid   in   1      consumer requests a word
//  pop_ready   out  1      pop accepted this cycle when pop_valid && pop_ready
//  rd_valid    out  1      rd_data holds popped word (1 cycle after pop accept)
//  rd_data     out  DW     popped word
//  count       out  AW+1   words stored, 0..DEPTH
//  full        out  1      count==DEPTH
//  empty       out  1      count==0
//  init_done   out  1      ram sweep finished; FIFO usable
//  ram_w       out  1      to ram w
//  ram_r       out  1      to ram r
//  ram_addr    out  AW     to ram addr
//  ram_din     out  DW     to ram data_in
//  ram_dout    in   DW     from ram data_out; valid the cycle after ram_r sampled high
// BEHAVIOUR
//  States: INIT, RUN. rst=1 -> next state INIT, init_ptr=0, wr_ptr=rd_ptr=0, count=0,
//   rd_valid=0, init_done=0. While rst=1: ram_w=ram_r=0, push_ready=pop_ready=0,
//   ram_addr=0, ram_din=0.
//  INIT: ram_w=1, ram_r=0, ram_addr=init_ptr, ram_din=0; init_ptr++ each cycle;
//   push_ready=pop_ready=0. After the cycle writing addr DEPTH-1 -> RUN; init_done=1 from
//   the first RUN cycle, held until rst. Sweep is exactly DEPTH cycles.
//  RUN (ram controls combinational from handshake, sampled by ram on the same edge):
//   pop_ready = !empty. push_ready = !full && !(pop_valid && !empty).
//   pop fire: ram_r=1, ram_addr=rd_ptr; rd_ptr++ (mod DEPTH).
//   push fire: ram_w=1, ram_addr=wr_ptr, ram_din=push_data; wr_ptr++ (mod DEPTH).
//   Neither: ram_w=ram_r=0, ram_addr=0, ram_din=0. ram_w and ram_r never both high.
//  Simultaneous push_valid and pop_valid, FIFO not empty: pop wins, push stalls one
//   cycle (push_ready=0); producer must hold push_data.
//  Empty: pop not accepted, including same-cycle push (no bypass).
//  Full: push not accepted; a pop frees a slot, push accepted the next cycle.
//  count: +1 on push fire, -1 on pop fire (never both in one cycle); full/empty from count.
//  Read latency: rd_valid is the registered pop fire, 1 cycle after accept;
//   rd_data = ram_dout while rd_valid=1. Back-to-back pops give 1 word/cycle.
//  Pointers are AW bits and wrap naturally; DEPTH != 2**AW is unsupported.
//  Reset mid-operation: an in-flight read is discarded (rd_valid=0 next cycle); FIFO
//   contents are lost; INIT sweep reruns from addr 0.
// TESTING
//  1 rst high 2 cycles, release -> 64 cycles ram_w=1, addr 0..63, din=0, readies low;
//    init_done=1 on cycle 65.
//  2 push 10,20,30 back-to-back -> ram writes at addr 0,1,2, count=3;
//    3 pops -> rd_valid 1 cycle after each, rd_data 10,20,30, count=0, empty=1.
//  3 push 64 words 0..63 -> full=1, push_ready=0, 65th push (100) held;
//    1 pop returns 0, then 100 written at addr 0 (wrap), count=64.
//  4 count=2, push_valid and pop_valid same cycle -> ram_r=1, push_ready=0;
//    push fires next cycle; count 2->1->2.
//  5 empty, pop_valid=1 -> pop_ready=0, no ram_r, rd_valid=0;
//    push 50 then pop -> rd_data=50.
//  6 count=5, pop accepted, rst=1 next edge -> rd_valid=0, count=0, empty=1;
//    INIT restarts at addr 0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_fifo_ctrl : in-order FIFO controller mastering a single-port RAM      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ram_fifo_ctrl #(
  parameter int DW    = 64,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop_valid,
  output logic          pop_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          init_done,
  output logic          ram_w,
  output logic          ram_r,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] init_ptr_q, init_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          init_done_q, init_done_d;
  logic          fifo_empty, fifo_full;
  logic          pop_fire, push_fire;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    init_done_d = init_done_q;
    rd_valid_d  = 1'b0;
    push_ready  = 1'b0;
    pop_ready   = 1'b0;
    pop_fire    = 1'b0;
    push_fire   = 1'b0;
    ram_w       = 1'b0;
    ram_r       = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    if (rst) begin
      // ram is left idle while reset is held; flops are cleared in always_ff
    end else if (state_q == INIT) begin
      ram_w      = 1'b1;
      ram_addr   = init_ptr_q;
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == LAST_ADDR) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end else begin
      // One ram port: a pending pop takes the cycle and the push waits
      pop_ready  = !fifo_empty;
      push_ready = !fifo_full && !(pop_valid && !fifo_empty);
      pop_fire   = pop_valid && pop_ready;
      push_fire  = push_valid && push_ready;
      rd_valid_d = pop_fire;
      if (pop_fire) begin
        ram_r    = 1'b1;
        ram_addr = rd_ptr_q;
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end else if (push_fire) begin
        ram_w    = 1'b1;
        ram_addr = wr_ptr_q;
        ram_din  = push_data;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? ram_dout : '0;
  assign count     = count_q;
  assign full      = fifo_full;
  assign empty     = fifo_empty;
  assign init_done = init_done_q;

endmodule
`default_nettype wire
